// File: rtl/reg_write_scoreboard_if.sv
// Issue/query/status bundle between the ID stage and the register write scoreboard.
interface reg_write_scoreboard_if #(
    parameter int unsigned STAT_W = 16
);
    logic              hold;
    logic              issue_wrt;
    logic [2:0]        issue_target;
    logic              rs_valid;
    logic [2:0]        rs;
    logic              rt_valid;
    logic [2:0]        rt;
    logic              STALL;
    logic [7:0]        busy_vec;
    logic [STAT_W-1:0] stall_cycles;

    // ID-stage side: drives issue and query, observes hazard status
    modport master (
        output hold, issue_wrt, issue_target, rs_valid, rs, rt_valid, rt,
        input  STALL, busy_vec, stall_cycles
    );

    // Scoreboard side
    modport slave (
        input  hold, issue_wrt, issue_target, rs_valid, rs, rt_valid, rt,
        output STALL, busy_vec, stall_cycles
    );
endinterface

// File: rtl/reg_write_scoreboard.sv
// Register write scoreboard: tracks in-flight destinations issued from ID
// until the register file can supply them, and raises STALL on RAW hazards.
module reg_write_scoreboard #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned STAT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_write_scoreboard_if.slave bus
);
    localparam int unsigned NREG = 8;

    logic [CNT_W-1:0]  cnt [NREG];
    logic [STAT_W-1:0] stat;
    logic [NREG-1:0]   busy_c;
    logic              stall_c;
    logic              issue_fire_c;

    // A register is busy while its countdown is non-zero
    always_comb begin
        busy_c = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_c[r] = (cnt[r] != '0);
        end
    end

    // RAW hazard on either read port; a stalled or frozen instruction never issues
    always_comb begin
        stall_c      = (bus.rs_valid & busy_c[bus.rs]) | (bus.rt_valid & busy_c[bus.rt]);
        issue_fire_c = bus.issue_wrt & ~stall_c & ~bus.hold;
    end

    // Per-register countdown: reload on issue, otherwise count down to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else if (!bus.hold) begin
            for (int r = 0; r < NREG; r++) begin
                if (issue_fire_c && (bus.issue_target == 3'(r))) begin
                    cnt[r] <= CNT_W'(DEPTH);
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    // Saturating stall-cycle counter; hold cycles with STALL still count
    always_ff @(posedge clk) begin
        if (rst) begin
            stat <= '0;
        end else if (stall_c && (stat != '1)) begin
            stat <= stat + STAT_W'(1);
        end
    end

    assign bus.STALL        = stall_c;
    assign bus.busy_vec     = busy_c;
    assign bus.stall_cycles = stat;
endmodule

// File: doc/reg_write_scoreboard.md
Name: reg_write_scoreboard

Overview:
- Producer-side counterpart to the ID-stage hazard check.
- Records every register write as it issues from ID into EX, and tracks the write until the value can be read from the register file.
- Answers RAW queries for the instruction currently in ID with a stall output.
- Keeps a per-register countdown and a saturating count of stall cycles.
- Sits beside the ID/EX pipeline register in the 5-stage 16-bit, 8-register pipeline.

Parameters:
- DEPTH, 2, number of cycles after issue during which a destination is unreadable (EX, MEM; the register file bypasses WB). Legal range 1..7.
- CNT_W, 3, width of each per-register countdown. Must satisfy 2^CNT_W > DEPTH.
- STAT_W, 16, width of the stall-cycle statistics counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- hold  input  1  pipeline freeze (memory busy). Freezes all countdowns and blocks issue.
- issue_wrt  input  1  instruction leaving ID writes a register.
- issue_target  input  3  destination register of the issuing instruction.
- rs_valid  input  1  ID instruction reads Rs.
- rs  input  3  ID instruction Rs field.
- rt_valid  input  1  ID instruction reads Rt.
- rt  input  3  ID instruction Rt field.
- STALL  output  1  RAW hazard; ID must hold and a bubble is inserted into EX.
- busy_vec  output  8  bit r = countdown[r] != 0.
- stall_cycles  output  STAT_W  saturating count of cycles with STALL=1.

Behaviour:
- State:
  - cnt[0..7], each CNT_W bits.
  - stat register, STAT_W bits.
- Reset (rst=1 at clock edge):
  - All cnt = 0 and stat = 0.
  - Outputs after reset: STALL=0 (while the valid inputs are 0), busy_vec=8'h00, stall_cycles=0.
  - rst has priority over hold and issue.
  - Reset mid-flight discards all pending entries.
- STALL is combinational from registered cnt and the current query inputs:
  - STALL = (rs_valid & busy_vec[rs]) | (rt_valid & busy_vec[rt]).
  - hold does not mask STALL.
- issue_fire = issue_wrt & ~STALL & ~hold. A stalled instruction never issues.
- Per-register update each edge when rst=0 and hold=0:
  - If issue_fire and issue_target == r: cnt[r] <= DEPTH. A WAW reissue to a busy register reloads to DEPTH; no merging.
  - Else if cnt[r] != 0: cnt[r] <= cnt[r] - 1.
  - Else cnt[r] holds at 0. Never underflows.
- When hold=1: all cnt hold and issue is ignored.
- Timing:
  - Write issued at edge N makes busy_vec[target]=1 in cycles N+1 .. N+DEPTH.
  - Clear in cycle N+DEPTH+1 (no hold).
  - Each hold cycle in between extends the busy window by one cycle.
- Same register for rs and rt: a single hazard. STALL is 1 if either valid bit is set and the register is busy.
- Query of a register whose cnt is 1 in the current cycle still stalls. The register is free the next cycle.
- stat update:
  - Increments by 1 on each edge with STALL=1 and rst=0, including hold cycles.
  - Saturates at 2^STAT_W-1; never wraps.
- No zero-register special case: all 8 registers are tracked identically.
- Multiple busy registers decrement independently in the same cycle.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then all inputs 0 for 5 cycles -> busy_vec=8'h00, STALL=0, stall_cycles=0 throughout.
- Basic RAW, DEPTH=2:
  - Stimulus: issue_wrt=1, issue_target=3 at edge 0; from cycle 1, rs_valid=1, rs=3.
  - Required: STALL=1 in cycles 1 and 2, STALL=0 in cycle 3, stall_cycles=2, busy_vec=8'h08 in cycles 1-2.
- Rt gating:
  - Stimulus: r5 busy; rt=5 with rt_valid=0.
  - Required: STALL=0. Then with rt_valid=1 -> STALL=1.
- WAW reload:
  - Stimulus: issue r2 at edge 0, issue r2 again at edge 1.
  - Required: busy_vec[2]=1 through cycle 3, clears in cycle 4.
- Stalled issue suppressed:
  - Stimulus: r1 busy, rs=1, rs_valid=1, issue_wrt=1, issue_target=6.
  - Required: cnt[6] stays 0 and busy_vec[6]=0.
- Hold and saturation:
  - Stimulus: issue r4, then hold=1 for 3 cycles.
  - Required: busy_vec[4] stays 1 for DEPTH+3 cycles total.
  - Stimulus (separate run): with STAT_W forced to 4, keep STALL=1 for 20 cycles.
  - Required: stall_cycles=15 and holds.
